top_level_cpu: RTL and testbench
================================

TOP_LEVEL_CPU -- requirements
Module: top_level_cpu

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0004, byte address of the first instruction fetched after reset.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 active  output  1  high while executing; falls once when the program halts.
REQ-005 register_v0  output  32  continuous copy of GPR $2.
REQ-006 address  output  32  Avalon byte address, always word-aligned.
REQ-007 write  output  1  Avalon write request.
REQ-008 read  output  1  Avalon read request.
REQ-009 waitrequest  input  1  Avalon stall; the current transfer is not accepted while it is high.
REQ-010 writedata  output  32  store data.
REQ-011 byteenable  output  4  byte lanes; always 4'b1111 for this instruction subset.
REQ-012 readdata  input  32  fetch/load data, valid in the cycle the transfer is accepted.

Function
REQ-013 Multicycle FSM with states FETCH, EXEC, MEM, WB and HALT.
REQ-014 FETCH:
- drive address=PC, read=1;
- stay in FETCH while waitrequest=1, holding address and read stable;
- when waitrequest=0, latch readdata into IR and go to EXEC.
REQ-015 EXEC:
- decode IR and compute the ALU result or effective address;
- loads and stores go to MEM; all other instructions go to WB.
REQ-016 MEM:
- LW drives read=1; SW drives write=1 with writedata=rt;
- address=rs+sign-extended imm16;
- hold all request outputs stable while waitrequest=1.
REQ-017 WB:
- write the destination register (rd for R-type, rt for I-type);
- update the PC;
- go to FETCH, or to HALT if the halt condition is met.
REQ-018 read and write are never both high; both are low in EXEC, WB and HALT.
REQ-019 Supported R-type instructions: ADDU, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, JR.
REQ-020 Supported I-type instructions:
- ADDIU, SLTI and SLTIU sign-extend imm16;
- ANDI, ORI and XORI zero-extend imm16;
- LUI loads imm16<<16;
- LW and SW use a sign-extended offset.
REQ-021 Arithmetic is 32-bit modulo 2^32 with no overflow traps.
REQ-022 Example: ADDIU $3,$0,0xF0F0 gives 0xFFFF_F0F0; a following XORI $2,$3,0x00FF gives 0xFFFF_F00F.
REQ-023 GPR $0 reads as 0; writes to $0 are discarded.
REQ-024 Word 0x0000_0000 is a NOP (SLL $0,$0,0).
REQ-025 PC normally advances by 4.
REQ-026 JR has one branch-delay slot:
- the instruction at PC+4 executes next;
- the PC then takes the jump target captured from rs at the JR.
REQ-027 Halt:
- triggered when the PC would become 0x0000_0000 after a completed delay slot;
- the FSM enters HALT and drives active=0, read=0, write=0;
- HALT is left only by reset.
REQ-028 Unsupported opcodes execute as NOPs; PC+4 still applies.
REQ-029 Memory word byte order is little-endian: lane 0 is address bits [7:0].

Reset
REQ-030 While reset=0 at a clock edge:
- PC=RESET_VECTOR, state=FETCH, active=1;
- read=0, write=0, all GPRs=0, the delay-slot flag is cleared.
REQ-031 Reset mid-transfer aborts the transfer in the same edge; the first fetch after reset deasserts is issued from RESET_VECTOR.

Structure
REQ-032 Shared package mips_pkg holds:
- opcode and funct constants;
- the FSM state enum;
- the RESET_VECTOR default.
REQ-033 Sub-module reg_file provides:
- 32x32 registers;
- two asynchronous read ports;
- one synchronous write port with $0 masked;
- a dedicated $2 output driving register_v0.
REQ-034 The ALU and the FSM live in top_level_cpu.

Verification
REQ-035 Program 0x04: 2403F0F0, 0x08: 386200FF, 0x0C: 00000008, 0x10: 0 -> active falls and register_v0=0xFFFF_F00F.
REQ-036 Program LUI $2,0x1234; ORI $2,$2,0x5678; JR $0 -> register_v0=0x1234_5678 at halt.
REQ-037 SW $3 to 0x100 with $3=0xDEAD_BEEF, then LW $2 from 0x100 -> writedata=0xDEAD_BEEF, byteenable=1111, register_v0=0xDEAD_BEEF.
REQ-038 waitrequest held high for 3 cycles on every transfer -> address/read/write stay stable throughout and the result is unchanged.
REQ-039 ADDIU $0,$0,5; ADDU $2,$0,$0 -> register_v0=0.
REQ-040 Reset pulled low during a fetch -> read drops on that edge and the next fetch is from 0x04.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : opcodes, functs, FSM states and reset vector for top_level_cpu
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0004;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// reg_file : 32x32 GPRs, two async read ports, one sync write port, $2 tap
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        we,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] v0
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we && (wr_addr != 5'd0)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign rs_data = (rs_addr == 5'd0) ? 32'd0 : regs_q[rs_addr];
  assign rt_data = (rt_addr == 5'd0) ? 32'd0 : regs_q[rt_addr];
  assign v0      = regs_q[2];

endmodule

`default_nettype wire

// File: rtl/top_level_cpu.sv
// ============================================================================
// top_level_cpu : multicycle MIPS-subset core with an Avalon-MM master port
// Rev 1.0
// ============================================================================
`default_nettype none

module top_level_cpu #(
  parameter logic [31:0] RESET_VECTOR = mips_pkg::RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  import mips_pkg::*;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] result_q, result_d;
  logic [31:0] target_q, target_d;
  logic        delay_q, delay_d;
  logic [31:0] address_q, address_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] writedata_q, writedata_d;
  logic        active_q, active_d;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_sext, imm_zext;
  logic [31:0] rs_val, rt_val;
  logic [31:0] alu_res, eff_addr, pc_next;
  logic [4:0]  dest;
  logic        wr_reg, is_lw, is_sw, is_jr, reg_we;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign imm_zext = {16'd0, ir_q[15:0]};
  assign eff_addr = rs_val + imm_sext;

  reg_file u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .rs_addr (rs),
    .rt_addr (rt),
    .rs_data (rs_val),
    .rt_data (rt_val),
    .we      (reg_we),
    .wr_addr (dest),
    .wr_data (result_q),
    .v0      (register_v0)
  );

  // Decode and ALU; unknown opcodes/functs leave wr_reg low and act as NOPs.
  always_comb begin
    alu_res = 32'd0;
    dest    = rt;
    wr_reg  = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_jr   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dest   = rd;
        wr_reg = 1'b1;
        case (funct)
          FN_ADDU: alu_res = rs_val + rt_val;
          FN_SUBU: alu_res = rs_val - rt_val;
          FN_AND:  alu_res = rs_val & rt_val;
          FN_OR:   alu_res = rs_val | rt_val;
          FN_XOR:  alu_res = rs_val ^ rt_val;
          FN_SLT:  alu_res = {31'd0, $signed(rs_val) < $signed(rt_val)};
          FN_SLTU: alu_res = {31'd0, rs_val < rt_val};
          FN_SLL:  alu_res = rt_val << shamt;
          FN_SRL:  alu_res = rt_val >> shamt;
          FN_SRA:  alu_res = $signed(rt_val) >>> shamt;
          FN_JR: begin
            is_jr  = 1'b1;
            wr_reg = 1'b0;
          end
          default: wr_reg = 1'b0;
        endcase
      end
      OP_ADDIU: begin alu_res = rs_val + imm_sext; wr_reg = 1'b1; end
      OP_SLTI:  begin alu_res = {31'd0, $signed(rs_val) < $signed(imm_sext)}; wr_reg = 1'b1; end
      OP_SLTIU: begin alu_res = {31'd0, rs_val < imm_sext}; wr_reg = 1'b1; end
      OP_ANDI:  begin alu_res = rs_val & imm_zext; wr_reg = 1'b1; end
      OP_ORI:   begin alu_res = rs_val | imm_zext; wr_reg = 1'b1; end
      OP_XORI:  begin alu_res = rs_val ^ imm_zext; wr_reg = 1'b1; end
      OP_LUI:   begin alu_res = {ir_q[15:0], 16'd0}; wr_reg = 1'b1; end
      OP_LW:    begin is_lw = 1'b1; wr_reg = 1'b1; end
      OP_SW:    is_sw = 1'b1;
      default:  wr_reg = 1'b0;
    endcase
  end

  assign pc_next = delay_q ? target_q : (pc_q + 32'd4);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    result_d    = result_q;
    target_d    = target_q;
    delay_d     = delay_q;
    address_d   = address_q;
    read_d      = read_q;
    write_d     = write_q;
    writedata_d = writedata_q;
    active_d    = active_q;
    reg_we      = 1'b0;
    case (state_q)
      ST_FETCH: begin
        // First FETCH cycle after reset has no request out yet; issue it here.
        if (!read_q) begin
          read_d    = 1'b1;
          address_d = pc_q;
        end else if (!waitrequest) begin
          ir_d    = readdata;
          read_d  = 1'b0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = alu_res;
        if (is_lw || is_sw) begin
          address_d   = {eff_addr[31:2], 2'b00};
          read_d      = is_lw;
          write_d     = is_sw;
          writedata_d = rt_val;
          state_d     = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (!waitrequest) begin
          if (is_lw) result_d = readdata;
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        reg_we  = wr_reg;
        pc_d    = pc_next;
        delay_d = is_jr;
        if (is_jr) target_d = {rs_val[31:2], 2'b00};
        // A finished delay slot heading to address zero ends the program.
        if (delay_q && (target_q == 32'd0)) begin
          state_d  = ST_HALT;
          active_d = 1'b0;
        end else begin
          state_d   = ST_FETCH;
          read_d    = 1'b1;
          address_d = pc_next;
        end
      end
      ST_HALT: begin
        read_d  = 1'b0;
        write_d = 1'b0;
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_VECTOR;
      ir_q        <= '0;
      result_q    <= '0;
      target_q    <= '0;
      delay_q     <= 1'b0;
      address_q   <= RESET_VECTOR;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      writedata_q <= '0;
      active_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      result_q    <= result_d;
      target_q    <= target_d;
      delay_q     <= delay_d;
      address_q   <= address_d;
      read_q      <= read_d;
      write_q     <= write_d;
      writedata_q <= writedata_d;
      active_q    <= active_d;
    end
  end

  assign active     = active_q;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = 4'b1111;

endmodule

`default_nettype wire

// File: tb/tb_top_level_cpu.sv
// ============================================================================
// tb_top_level_cpu : directed program vectors for top_level_cpu with a
// wait-state Avalon memory model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_top_level_cpu;

  typedef struct packed {
    logic [9:0][31:0] prog;
    logic [31:0]      exp_v0;
    logic [3:0]       wait_n;
    logic             chk_store;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        active;
  logic [31:0] register_v0;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  logic [31:0] prog_mem [64];
  logic [31:0] data_mem [16];
  int          wait_cycles;
  int          wait_cnt;

  int          checks;
  int          errors;
  int          bus_err;
  int          stall_err;
  int          stall_seen;
  bit          prev_stall;
  logic [31:0] prev_addr, prev_wd, last_wdata;
  logic        prev_rd, prev_wr;
  logic [3:0]  last_be;

  vec_t        vecs [12];

  top_level_cpu dut (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .register_v0 (register_v0),
    .address     (address),
    .write       (write),
    .read        (read),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program region 0x000-0x0FF, data region 0x100-0x13F.
  assign readdata    = (address[9:8] == 2'b01) ? data_mem[address[5:2]] : prog_mem[address[7:2]];
  assign waitrequest = (read || write) && (wait_cnt < wait_cycles);

  always @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= 0;
      for (int i = 0; i < 16; i++) data_mem[i] <= '0;
    end else if (read || write) begin
      if (waitrequest) begin
        wait_cnt <= wait_cnt + 1;
      end else begin
        wait_cnt <= 0;
        if (write && address[9:8] == 2'b01) data_mem[address[5:2]] <= writedata;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  // Bus protocol monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (read && write) bus_err++;
      if ((read || write) && (address[1:0] != 2'b00)) bus_err++;
      if ((read || write) && (byteenable != 4'hF)) bus_err++;
      if (prev_stall && (address != prev_addr || read != prev_rd ||
                         write != prev_wr || writedata != prev_wd)) stall_err++;
      if (write && !waitrequest) begin
        last_wdata = writedata;
        last_be    = byteenable;
      end
      prev_stall = (read || write) && waitrequest;
      if (prev_stall) stall_seen++;
      prev_addr = address;
      prev_rd   = read;
      prev_wr   = write;
      prev_wd   = writedata;
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] exp, input logic [3:0] wt, input logic st,
                              input logic [31:0] w0 = 0, input logic [31:0] w1 = 0,
                              input logic [31:0] w2 = 0, input logic [31:0] w3 = 0,
                              input logic [31:0] w4 = 0, input logic [31:0] w5 = 0,
                              input logic [31:0] w6 = 0, input logic [31:0] w7 = 0,
                              input logic [31:0] w8 = 0, input logic [31:0] w9 = 0);
    vec_t v;
    v.prog[0] = w0; v.prog[1] = w1; v.prog[2] = w2; v.prog[3] = w3; v.prog[4] = w4;
    v.prog[5] = w5; v.prog[6] = w6; v.prog[7] = w7; v.prog[8] = w8; v.prog[9] = w9;
    v.exp_v0    = exp;
    v.wait_n    = wt;
    v.chk_store = st;
    return v;
  endfunction

  task automatic load_prog(input vec_t v);
    for (int i = 0; i < 64; i++) prog_mem[i] = 32'd0;
    for (int i = 0; i < 10; i++) prog_mem[i + 1] = v.prog[i];
    wait_cycles = int'(v.wait_n);
  endtask

  task automatic wait_halt(output bit halted);
    halted = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!active) begin
        halted = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, output bit halted);
    reset = 1'b0;
    load_prog(v);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_halt(halted);
  endtask

  initial begin
    bit halted;
    bit found;
    checks = 0; errors = 0; bus_err = 0; stall_err = 0; stall_seen = 0;
    prev_stall = 1'b0;
    last_wdata = '0; last_be = '0;
    reset = 1'b0;
    wait_cycles = 0;

    vecs[0]  = mk(32'hFFFF_F00F, 4'd0, 1'b0, 32'h2403F0F0, 32'h386200FF, 32'h00000008, 32'h0);
    vecs[1]  = mk(32'hFFFF_F00F, 4'd3, 1'b0, 32'h2403F0F0, 32'h386200FF, 32'h00000008, 32'h0);
    vecs[2]  = mk(32'h1234_5678, 4'd0, 1'b0, 32'h3C021234, 32'h34425678, 32'h00000008, 32'h0);
    vecs[3]  = mk(32'hDEAD_BEEF, 4'd0, 1'b1, 32'h3C03DEAD, 32'h3463BEEF, 32'hAC030100,
                  32'h8C020100, 32'h00000008, 32'h0);
    vecs[4]  = mk(32'hDEAD_BEEF, 4'd3, 1'b1, 32'h3C03DEAD, 32'h3463BEEF, 32'hAC030100,
                  32'h8C020100, 32'h00000008, 32'h0);
    vecs[5]  = mk(32'h0000_0000, 4'd1, 1'b0, 32'h24020007, 32'h24000005, 32'h00001021,
                  32'h00000008, 32'h0);
    vecs[6]  = mk(32'h0FFF_FFFF, 4'd0, 1'b0, 32'h2403FFFF, 32'h00031102, 32'h00000008, 32'h0);
    vecs[7]  = mk(32'h0000_0011, 4'd2, 1'b0, 32'h2403FFFF, 32'h24040001, 32'h0064282A,
                  32'h0083302B, 32'h00063100, 32'h00A61025, 32'h00000008, 32'h0);
    vecs[8]  = mk(32'h0000_FFFB, 4'd0, 1'b0, 32'h24030005, 32'h00032023, 32'h3082FFFF,
                  32'h00000008, 32'h0);
    vecs[9]  = mk(32'hFFFF_F800, 4'd0, 1'b0, 32'h24038000, 32'h00031103, 32'h00000008, 32'h0);
    vecs[10] = mk(32'h0000_0055, 4'd1, 1'b0, 32'h24020055, 32'hFC020000, 32'h0000103F,
                  32'h00000008, 32'h0);
    vecs[11] = mk(32'h0000_0011, 4'd0, 1'b0, 32'h24050020, 32'h00A00008, 32'h24020001,
                  32'h24420100, 32'h24420100, 32'h24420100, 32'h24420100, 32'h24420010,
                  32'h00000008, 32'h0);

    // Reset state.
    load_prog(vecs[0]);
    repeat (3) @(negedge clk);
    check32("rst_read", {31'd0, read}, 32'd0);
    check32("rst_write", {31'd0, write}, 32'd0);
    check32("rst_active", {31'd0, active}, 32'd1);
    check32("rst_v0", register_v0, 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], halted);
      check32($sformatf("vec%0d_halt", i), {31'd0, halted}, 32'd1);
      check32($sformatf("vec%0d_v0", i), register_v0, vecs[i].exp_v0);
      if (vecs[i].chk_store) begin
        check32($sformatf("vec%0d_wdata", i), last_wdata, 32'hDEAD_BEEF);
        check32($sformatf("vec%0d_be", i), {28'd0, last_be}, 32'h0000_000F);
        check32($sformatf("vec%0d_mem", i), data_mem[0], 32'hDEAD_BEEF);
      end
    end

    // Halt is sticky with the bus idle.
    repeat (6) @(negedge clk);
    check32("halt_idle", {29'd0, active, read, write}, 32'd0);

    // Register file clears on reset.
    reset = 1'b0;
    @(negedge clk);
    check32("rst_gpr_v0", register_v0, 32'd0);

    // Reset during a stalled fetch from 0x08 aborts it; next fetch is from 0x04.
    load_prog(vecs[1]);
    @(negedge clk);
    reset = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (read && waitrequest && address == 32'h0000_0008) begin
        found = 1'b1;
        break;
      end
    end
    check32("abort_reach", {31'd0, found}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check32("abort_read", {30'd0, read, write}, 32'd0);
    reset = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (read) begin
        found = 1'b1;
        break;
      end
    end
    check32("refetch_seen", {31'd0, found}, 32'd1);
    check32("refetch_addr", address, 32'h0000_0004);
    wait_halt(halted);
    check32("abort_halt", {31'd0, halted}, 32'd1);
    check32("abort_v0", register_v0, 32'hFFFF_F00F);

    check32("bus_rules", bus_err, 32'd0);
    check32("stall_stable", stall_err, 32'd0);
    check32("stalls_seen", {31'd0, stall_seen != 0}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
